// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : 5-stage MIPS hazard unit. Generates stalls, flushes and forwards,
//            tracks mult/div occupancy and counts stall cycles.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeRegE,
  input  logic [4:0]       writeRegM,
  input  logic [4:0]       writeRegW,
  input  logic             regWriteE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memToRegE,
  input  logic             memToRegM,
  input  logic             branchD,
  input  logic             multD,
  input  logic             mfhiloD,
  input  logic             multStartE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [3:0]       MD_RELOAD = 4'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  md_state_e        state_q, state_d;
  logic [3:0]       mdCnt_q, mdCnt_d;
  logic [CNT_W-1:0] stallCount_q, stallCount_d;

  logic       lwstall, branchstall, mdstall, stall_raw;
  logic [1:0] fwdAE_raw, fwdBE_raw;
  logic       fwdAD_raw, fwdBD_raw;

  // Register $0 never produces a match, so every comparison is qualified by a non-zero index.
  always_comb begin
    fwdAE_raw = 2'b00;
    if ((rsE != 5'd0) && (rsE == writeRegM) && regWriteM)      fwdAE_raw = 2'b10;
    else if ((rsE != 5'd0) && (rsE == writeRegW) && regWriteW) fwdAE_raw = 2'b01;

    fwdBE_raw = 2'b00;
    if ((rtE != 5'd0) && (rtE == writeRegM) && regWriteM)      fwdBE_raw = 2'b10;
    else if ((rtE != 5'd0) && (rtE == writeRegW) && regWriteW) fwdBE_raw = 2'b01;

    fwdAD_raw = (rsD != 5'd0) && (rsD == writeRegM) && regWriteM;
    fwdBD_raw = (rtD != 5'd0) && (rtD == writeRegM) && regWriteM;

    lwstall = memToRegE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));

    branchstall = branchD &&
      ((regWriteE && (writeRegE != 5'd0) && ((writeRegE == rsD) || (writeRegE == rtD))) ||
       (memToRegM && (writeRegM != 5'd0) && ((writeRegM == rsD) || (writeRegM == rtD))));

    mdstall   = (mfhiloD || multD) && ((state_q == BUSY) || multStartE);
    stall_raw = lwstall || branchstall || mdstall;
  end

  always_comb begin
    stallF    = stall_raw && !reset;
    stallD    = stall_raw && !reset;
    flushE    = stall_raw && !reset;
    forwardAD = fwdAD_raw && !reset;
    forwardBD = fwdBD_raw && !reset;
    forwardAE = reset ? 2'b00 : fwdAE_raw;
    forwardBE = reset ? 2'b00 : fwdBE_raw;
  end

  // Mult/div occupancy: a start while BUSY always reloads, covering back-to-back issue.
  always_comb begin
    state_d = state_q;
    mdCnt_d = mdCnt_q;
    case (state_q)
      IDLE: begin
        if (multStartE) begin
          state_d = BUSY;
          mdCnt_d = MD_RELOAD;
        end
      end
      BUSY: begin
        if (multStartE) begin
          mdCnt_d = MD_RELOAD;
        end else if (mdCnt_q != 4'd0) begin
          mdCnt_d = mdCnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        mdCnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    stallCount_d = stallCount_q;
    if (stall_raw && (stallCount_q != CNT_MAX)) stallCount_d = stallCount_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mdCnt_q      <= 4'd0;
      stallCount_q <= '0;
    end else begin
      state_q      <= state_d;
      mdCnt_q      <= mdCnt_d;
      stallCount_q <= stallCount_d;
    end
  end

  assign mdBusy     = (state_q == BUSY);
  assign stallCount = stallCount_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Self-checking bench for hazard_ctrl: table-driven combinational vectors plus
// directed multi-cycle sequences (mult/div occupancy, reset abort, saturation).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
  logic       branchD, multD, mfhiloD, multStartE;

  logic        stallF, stallD, flushE, forwardAD, forwardBD, mdBusy;
  logic [1:0]  forwardAE, forwardBE;
  logic [15:0] stallCount;

  logic        s_stallF, s_stallD, s_flushE, s_forwardAD, s_forwardBD, s_mdBusy;
  logic [1:0]  s_forwardAE, s_forwardBE;
  logic [2:0]  s_stallCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM), .branchD(branchD),
    .multD(multD), .mfhiloD(mfhiloD), .multStartE(multStartE),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdBusy(mdBusy), .stallCount(stallCount)
  );

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM), .branchD(branchD),
    .multD(multD), .mfhiloD(mfhiloD), .multStartE(multStartE),
    .stallF(s_stallF), .stallD(s_stallD), .flushE(s_flushE),
    .forwardAD(s_forwardAD), .forwardBD(s_forwardBD),
    .forwardAE(s_forwardAE), .forwardBE(s_forwardBE),
    .mdBusy(s_mdBusy), .stallCount(s_stallCount)
  );

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, mtE, mtM, br, mul, mfhilo, start;
    logic [1:0] fAE, fBE;
    logic       fAD, fBD, stl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, ".stallF"}, 32'(stallF), 32'(exp));
    chk({name, ".stallD"}, 32'(stallD), 32'(exp));
    chk({name, ".flushE"}, 32'(flushE), 32'(exp));
  endtask

  task automatic apply(input vec_t v);
    rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    writeRegE = v.wE; writeRegM = v.wM; writeRegW = v.wW;
    regWriteE = v.rwE; regWriteM = v.rwM; regWriteW = v.rwW;
    memToRegE = v.mtE; memToRegM = v.mtM; branchD = v.br;
    multD = v.mul; mfhiloD = v.mfhilo; multStartE = v.start;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply('0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin : main
    vec_t v;
    int   exp_cnt;

    // Forwarding, load-use and branch vectors; start-issue vector is last.
    v = '0; v.rsE = 5; v.wM = 5; v.rwM = 1; v.wW = 5; v.rwW = 1; v.fAE = 2'b10; tbl.push_back(v);
    v = '0; v.rsE = 5; v.wM = 5; v.rwM = 0; v.wW = 5; v.rwW = 1; v.fAE = 2'b01; tbl.push_back(v);
    v = '0; v.rsE = 0; v.wM = 5; v.rwM = 1; v.wW = 5; v.rwW = 1; tbl.push_back(v);
    v = '0; v.rsE = 7; v.rtE = 7; v.wM = 7; v.rwM = 1; v.wW = 7; v.rwW = 1; v.fAE = 2'b10; v.fBE = 2'b10; tbl.push_back(v);
    v = '0; v.rtE = 9; v.wW = 9; v.rwW = 1; v.wM = 4; v.rwM = 1; v.fBE = 2'b01; tbl.push_back(v);
    v = '0; v.rsD = 6; v.rtD = 6; v.wM = 6; v.rwM = 1; v.fAD = 1; v.fBD = 1; tbl.push_back(v);
    v = '0; v.rwM = 1; v.rwW = 1; v.rwE = 1; v.br = 1; tbl.push_back(v);
    v = '0; v.mtE = 1; v.rtE = 8; v.rsD = 8; v.stl = 1; tbl.push_back(v);
    v = '0; v.mtE = 1; v.rtE = 8; v.rtD = 8; v.stl = 1; tbl.push_back(v);
    v = '0; v.mtE = 1; v.rtE = 0; v.rsD = 0; v.rtD = 0; tbl.push_back(v);
    v = '0; v.mtE = 0; v.rtE = 8; v.rsD = 8; tbl.push_back(v);
    v = '0; v.br = 1; v.rsD = 3; v.rwE = 1; v.wE = 3; v.stl = 1; tbl.push_back(v);
    v = '0; v.br = 1; v.rsD = 3; v.wM = 3; v.rwM = 1; v.fAD = 1; tbl.push_back(v);
    v = '0; v.br = 1; v.rtD = 4; v.wM = 4; v.mtM = 1; v.rwM = 1; v.fBD = 1; v.stl = 1; tbl.push_back(v);
    v = '0; v.br = 0; v.rsD = 3; v.rwE = 1; v.wE = 3; tbl.push_back(v);
    v = '0; v.br = 1; v.rsD = 3; v.rwE = 0; v.wE = 3; tbl.push_back(v);
    v = '0; v.mtE = 1; v.rtE = 2; v.rsD = 2; v.br = 1; v.rwE = 1; v.wE = 2; v.stl = 1; tbl.push_back(v);
    v = '0; v.mul = 1; tbl.push_back(v);
    v = '0; v.mul = 1; v.start = 1; v.stl = 1; tbl.push_back(v);

    // Reset: outputs forced low even with hazards present on the inputs.
    reset = 1'b1;
    v = '0; v.mtE = 1; v.rtE = 8; v.rsD = 8; v.rsE = 5; v.wM = 5; v.rwM = 1; v.br = 1; v.wE = 8; v.rwE = 1;
    apply(v);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_stall("reset_force", 1'b0);
    chk("reset_forwardAE", 32'(forwardAE), 32'd0);
    chk("reset_forwardAD", 32'(forwardAD), 32'd0);
    chk("reset_stallCount", 32'(stallCount), 32'd0);
    chk("reset_mdBusy", 32'(mdBusy), 32'd0);

    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d.forwardAE", i), 32'(forwardAE), 32'(tbl[i].fAE));
      chk($sformatf("vec%0d.forwardBE", i), 32'(forwardBE), 32'(tbl[i].fBE));
      chk($sformatf("vec%0d.forwardAD", i), 32'(forwardAD), 32'(tbl[i].fAD));
      chk($sformatf("vec%0d.forwardBD", i), 32'(forwardBD), 32'(tbl[i].fBD));
      chk_stall($sformatf("vec%0d", i), tbl[i].stl);
      chk($sformatf("vec%0d.stallCount", i), 32'(stallCount), 32'(exp_cnt));
      if (tbl[i].stl) exp_cnt++;
      next_cycle();
    end
    apply('0);
    @(negedge clk);
    chk("table_stallCount", 32'(stallCount), 32'(exp_cnt));

    // Mult/div single issue with mfhi held: busy 4 cycles, stall 5.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      mfhiloD = 1'b1;
      multStartE = (k == 0);
      @(negedge clk);
      chk($sformatf("md%0d.mdBusy", k), 32'(mdBusy), 32'((k >= 1) && (k <= 4)));
      chk_stall($sformatf("md%0d", k), (k <= 4));
      chk($sformatf("md%0d.stallCount", k), 32'(stallCount), 32'((k < 5) ? k : 5));
      next_cycle();
    end

    // Back-to-back issue on the final busy cycle keeps the unit busy.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      multStartE = (k == 0) || (k == 4);
      @(negedge clk);
      chk($sformatf("b2b%0d.mdBusy", k), 32'(mdBusy), 32'((k >= 1) && (k <= 8)));
      next_cycle();
    end
    multStartE = 1'b0;

    // Reset two cycles after issue aborts the operation.
    do_reset();
    mfhiloD = 1'b1;
    multStartE = 1'b1;
    next_cycle();
    multStartE = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("abort_pre.mdBusy", 32'(mdBusy), 32'd1);
    chk("abort_pre.stallCount", 32'(stallCount), 32'd2);
    reset = 1'b1;
    #1;
    chk_stall("abort_in_reset", 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_post.mdBusy", 32'(mdBusy), 32'd0);
    chk("abort_post.stallCount", 32'(stallCount), 32'd0);
    chk_stall("abort_post", 1'b0);
    next_cycle();
    mfhiloD = 1'b0;

    // Saturation: 3-bit counter sticks at 7 while 16-bit keeps counting.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      if (k < 10) begin
        memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
      end else begin
        apply('0);
      end
      @(negedge clk);
      chk($sformatf("sat%0d.stallCount3", k), 32'(s_stallCount), 32'((k < 7) ? k : 7));
      chk($sformatf("sat%0d.stallCount16", k), 32'(stallCount), 32'(k));
      chk($sformatf("sat%0d.stallF", k), 32'(s_stallF), 32'(k < 10));
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
